// File: rtl/ifu_fetch_ctrl_pkg.sv
// ifu_fetch_ctrl_pkg: fetch-window geometry helpers shared by the fetch front-end
package ifu_fetch_ctrl_pkg;
    function automatic int fw_of(input int p_fw);
        return 1 << p_fw;
    endfunction
    function automatic int stage_w(input int aw, input int p_fw);
        return 1 + aw + p_fw + 1;
    endfunction
    function automatic logic [63:0] align_mask(input int p_insn, input int p_fw);
        return ~((64'd1 << (p_insn + p_fw)) - 64'd1);
    endfunction
endpackage

// File: rtl/ifu_fetch_ctrl_stage.sv
// ifu_fetch_ctrl_stage: one fetch pipeline stage register with hold-on-stall and synchronous kill
module ifu_fetch_ctrl_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         kill_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_o <= '0;
        else if (kill_i) q_o <= '0;
        else if (!stall_i) q_o <= d_i;
    end
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch PC owner, window launcher and stage tracker with IQ credit gating
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter int CONFIG_AW = 32,
    parameter int CONFIG_P_FETCH_WIDTH = 2,
    parameter int CONFIG_P_INSN_LEN = 2,
    parameter int CONFIG_N_STAGES = 2,
    parameter int CONFIG_P_IQ_DEPTH = 4,
    parameter logic [CONFIG_AW-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [CONFIG_AW-1:0]           flush_tgt,
    input  logic                           stall,
    output logic                           fe_req,
    output logic [CONFIG_AW-1:0]           fe_vaddr,
    output logic [CONFIG_AW-1:0]           fe_pc,
    input  logic                           bpu_valid,
    input  logic [CONFIG_P_FETCH_WIDTH-1:0] bpu_slot,
    input  logic [CONFIG_AW-1:0]           bpu_tgt,
    output logic                           out_valid,
    output logic [CONFIG_AW-1:0]           out_pc,
    output logic [CONFIG_P_FETCH_WIDTH:0]  out_cnt,
    input  logic [CONFIG_P_IQ_DEPTH:0]     iq_pop_cnt,
    output logic [CONFIG_P_IQ_DEPTH:0]     credit
);
    localparam int FW = fw_of(CONFIG_P_FETCH_WIDTH);
    localparam int PFW = CONFIG_P_FETCH_WIDTH;
    localparam int PIL = CONFIG_P_INSN_LEN;
    localparam int NS = CONFIG_N_STAGES;
    localparam int KW = PFW + 1;
    localparam int CW = CONFIG_P_IQ_DEPTH + 1;
    localparam int SW = stage_w(CONFIG_AW, PFW);
    localparam logic [CONFIG_AW-1:0] ALIGN = CONFIG_AW'(align_mask(PIL, PFW));
    localparam logic [CONFIG_AW-1:0] WIN_BYTES = CONFIG_AW'(FW << PIL);
    localparam logic [CW-1:0] DEPTH = CW'(1 << CONFIG_P_IQ_DEPTH);

    logic [CONFIG_AW-1:0] pc_q, pc_d;
    logic [CW-1:0]        credit_q, credit_d;
    logic [CW+1:0]        credit_sum;
    logic [SW-1:0]        st_q [NS];
    logic [SW-1:0]        st_d [NS];
    logic [SW-1:0]        s1_adv;
    logic [PFW-1:0]       off, s1_off;
    logic                 redirect, consume;

    // stage layout: {valid, pc, cnt}; a redirect trims stage 1's count as it moves on
    always_comb begin
        off = pc_q[PIL +: PFW];
        s1_off = st_q[0][KW + PIL +: PFW];
        redirect = bpu_valid & st_q[0][SW-1] & ~stall & ~flush & (bpu_slot >= s1_off);
        fe_req = rst & ~stall & ~flush & ~redirect & (credit_q >= CW'(FW));
        fe_vaddr = pc_q & ALIGN;
        fe_pc = pc_q;
        s1_adv = redirect ? {st_q[0][SW-1:KW], KW'(bpu_slot - s1_off) + KW'(1)} : st_q[0];
        st_d[0] = fe_req ? {1'b1, pc_q, KW'(FW) - KW'(off)} : '0;
        for (int k = 1; k < NS; k++) st_d[k] = (k == 1) ? s1_adv : st_q[k-1];
        {out_valid, out_pc, out_cnt} = (NS == 1) ? s1_adv : st_q[NS-1];
        consume = out_valid & ~stall;
        credit_sum = (CW+2)'(credit_q) - (fe_req ? (CW+2)'(FW) : '0)
                   + (consume ? (CW+2)'(FW) - (CW+2)'(out_cnt) : '0) + (CW+2)'(iq_pop_cnt);
        credit_d = flush ? DEPTH : credit_sum[CW-1:0];
        pc_d = flush ? flush_tgt : redirect ? bpu_tgt : fe_req ? fe_vaddr + WIN_BYTES : pc_q;
        credit = credit_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
            credit_q <= DEPTH;
        end else begin
            pc_q <= pc_d;
            credit_q <= credit_d;
        end
    end

    // an underflow wraps to a huge unsigned value, so one bound covers both directions
    assert property (@(posedge clk) disable iff (!rst) flush || credit_sum <= (CW+2)'(DEPTH));

    for (genvar i = 0; i < NS; i++) begin : g_stage
        ifu_fetch_ctrl_stage #(.W(SW)) u_stage (
            .clk(clk),
            .rst(rst),
            .stall_i(stall),
            .kill_i(flush),
            .d_i(st_d[i]),
            .q_o(st_q[i])
        );
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed vectors with a scoreboard queue of expected fetch windows
module tb_ifu_fetch_ctrl;
    logic        clk = 0, rst = 0, flush = 0, stall = 0, bpu_valid = 0;
    logic [31:0] flush_tgt = 0, bpu_tgt = 0;
    logic [1:0]  bpu_slot = 0;
    logic [4:0]  iq_pop_cnt = 0;
    logic        fe_req, out_valid;
    logic [31:0] fe_vaddr, fe_pc, out_pc;
    logic [2:0]  out_cnt;
    logic [4:0]  credit;
    int          checks = 0, errors = 0;
    logic [34:0] exp_q [$];

    ifu_fetch_ctrl #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_tgt(flush_tgt), .stall(stall),
        .fe_req(fe_req), .fe_vaddr(fe_vaddr), .fe_pc(fe_pc),
        .bpu_valid(bpu_valid), .bpu_slot(bpu_slot), .bpu_tgt(bpu_tgt),
        .out_valid(out_valid), .out_pc(out_pc), .out_cnt(out_cnt),
        .iq_pop_cnt(iq_pop_cnt), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one cycle: drive inputs, optionally queue the window this launch should produce, check at negedge
    task automatic vec(input int er, input int eva, input int ec, input int pu, input int ppc, input int pcn,
                       input int s = 0, input int f = 0, input int ft = 0, input int bv = 0,
                       input int sl = 0, input int bt = 0, input int pp = 0);
        stall = s[0];
        flush = f[0];
        flush_tgt = 32'(ft);
        bpu_valid = bv[0];
        bpu_slot = 2'(sl);
        bpu_tgt = 32'(bt);
        iq_pop_cnt = 5'(pp);
        if (pu != 0) exp_q.push_back({32'(ppc), 3'(pcn)});
        @(negedge clk);
        chk("fe_req", 32'(fe_req), 32'(er));
        if (er != 0) chk("fe_vaddr", fe_vaddr, 32'(eva));
        chk("credit", 32'(credit), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got pc=%h cnt=%0d, expected no window", out_pc, out_cnt);
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                chk("out_pc", out_pc, e[34:3]);
                chk("out_cnt", 32'(out_cnt), 32'(e[2:0]));
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        vec(0, 0, 16, 0, 0, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_cnt", 32'(out_cnt), 0);
        rst = 1;
        vec(1, 'h100, 16, 1, 'h100, 4);
        vec(1, 'h110, 12, 1, 'h110, 4);
        vec(1, 'h120, 8, 1, 'h120, 4);
        vec(1, 'h130, 4, 1, 'h130, 4);
        vec(0, 0, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        vec(1, 'h140, 4, 1, 'h140, 4);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
        vec(1, 'h150, 12, 1, 'h150, 4);
        vec(1, 'h160, 8, 1, 'h160, 4);
        vec(0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        vec(0, 0, 6, 0, 0, 0, 1);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_out_pc", out_pc, 'h150);
        chk("stall_out_cnt", 32'(out_cnt), 4);
        vec(0, 0, 6, 0, 0, 0, 1);
        vec(1, 'h170, 6, 0, 0, 0);
        vec(0, 0, 2, 0, 0, 0, 0, 1, 'h10C);
        vec(1, 'h100, 16, 1, 'h10C, 1);
        vec(1, 'h110, 12, 0, 0, 0);
        vec(0, 0, 8, 0, 0, 0, 0, 1, 'h200);
        vec(1, 'h200, 16, 1, 'h200, 2);
        vec(0, 0, 12, 0, 0, 0, 0, 0, 0, 1, 1, 'h400);
        vec(1, 'h400, 12, 0, 0, 0);
        vec(0, 0, 10, 0, 0, 0, 1, 1, 'h300, 1, 3, 'h500, 2);
        stall = 0;
        flush = 0;
        bpu_valid = 0;
        iq_pop_cnt = 0;
        vec(1, 'h300, 16, 1, 'h300, 4);
        vec(1, 'h310, 12, 0, 0, 0);
        vec(1, 'h320, 8, 0, 0, 0);
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        #1 rst = 0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_out_cnt", 32'(out_cnt), 0);
        chk("async_fe_req", 32'(fe_req), 0);
        chk("async_credit", 32'(credit), 16);
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
